// File: rtl/external_memory_waited.sv
// Byte-addressed scratch memory with a waited 1/2/4-byte data port and a single-cycle
// 16-bit fetch port. Storage is split into four byte banks so any unaligned access touches each bank at most once.
module external_memory_waited #(
    parameter int          MEM_BYTES   = 1024,
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [15:0] FAULT_FETCH = 16'hE800
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_fault,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_valid,
    output logic [15:0]       f_data
);

    localparam int              ROWS      = (MEM_BYTES + 3) / 4;
    localparam int              RIDX_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);
    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rvalid_q, rvalid_d;
    logic              fault_q, fault_d;
    logic              rd_ok_q, rd_ok_d;
    logic [1:0]        rd_rot_q, rd_rot_d;
    logic [2:0]        rd_n_q, rd_n_d;
    logic              fv_q, fv_d;
    logic              f_has_q, f_has_d;
    logic              f_flt_q, f_flt_d;
    logic [1:0]        f_base_q, f_base_d;

    logic [2:0]        acc_n;
    logic [ADDR_W:0]   acc_end;
    logic              acc_valid;
    logic              commit;
    logic              accept;
    logic [ADDR_W:0]   f_end;
    logic              f_ok;
    logic [1:0]        f_hi_sel;
    logic [3:0][7:0]   d_bank_rdata;
    logic [3:0][7:0]   f_bank_rdata;

    // Validity uses the captured request; sums are one bit wider so the top of memory cannot wrap.
    always_comb begin
        case (size_q)
            2'd0:    acc_n = 3'd1;
            2'd1:    acc_n = 3'd2;
            2'd2:    acc_n = 3'd4;
            default: acc_n = 3'd1;
        endcase
        acc_end   = {1'b0, addr_q} + (ADDR_W + 1)'(acc_n) - 1'b1;
        acc_valid = (size_q != 2'd3) && (acc_end < MEM_LIMIT);
        f_end     = {1'b0, f_addr} + 1'b1;
        f_ok      = f_end < MEM_LIMIT;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rvalid_d = 1'b0;
        fault_d  = 1'b0;
        rd_ok_d  = rd_ok_q;
        rd_rot_d = rd_rot_q;
        rd_n_d   = rd_n_q;
        commit   = 1'b0;
        accept   = 1'b0;

        case (state_q)
            IDLE: begin
                accept = d_req;
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit   = 1'b1;
                    state_d  = RESP;
                    rvalid_d = 1'b1;
                    fault_d  = !acc_valid;
                    if (!we_q) begin
                        rd_ok_d  = acc_valid;
                        rd_rot_d = addr_q[1:0];
                        rd_n_d   = acc_n;
                    end
                end
            end
            RESP: begin
                accept  = d_req;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            we_d    = d_we;
            size_d  = d_size;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            cnt_d   = WAIT_INIT;
            state_d = ACCESS;
        end
    end

    always_comb begin
        fv_d     = f_req;
        f_has_d  = f_has_q;
        f_flt_d  = f_flt_q;
        f_base_d = f_base_q;
        if (f_req) begin
            f_has_d  = 1'b1;
            f_flt_d  = !f_ok;
            f_base_d = f_addr[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
            rd_ok_q  <= 1'b0;
            rd_rot_q <= 2'd0;
            rd_n_q   <= 3'd0;
            fv_q     <= 1'b0;
            f_has_q  <= 1'b0;
            f_flt_q  <= 1'b0;
            f_base_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            fault_q  <= fault_d;
            rd_ok_q  <= rd_ok_d;
            rd_rot_q <= rd_rot_d;
            rd_n_q   <= rd_n_d;
            fv_q     <= fv_d;
            f_has_q  <= f_has_d;
            f_flt_q  <= f_flt_d;
            f_base_q <= f_base_d;
        end
    end

    // Bank gi holds every byte whose address is gi modulo 4; its lane is the distance from the base address.
    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
        logic [7:0]        mem [ROWS];
        logic [1:0]        d_lane;
        logic [1:0]        f_lane;
        logic [ADDR_W:0]   d_byte;
        logic [ADDR_W:0]   f_byte;
        logic [RIDX_W-1:0] d_row;
        logic [RIDX_W-1:0] f_row;
        logic [7:0]        wr_byte;
        logic [7:0]        d_rd_q;
        logic [7:0]        f_rd_q;
        logic              wr_en;
        logic              rd_en;
        logic              f_en;

        always_comb begin
            d_lane  = 2'(gi) - addr_q[1:0];
            d_byte  = {1'b0, addr_q} + (ADDR_W + 1)'(d_lane);
            d_row   = RIDX_W'(d_byte >> 2);
            wr_byte = wdata_q[{d_lane, 3'b000} +: 8];
            wr_en   = commit && !srst && we_q && acc_valid && ({1'b0, d_lane} < acc_n);
            rd_en   = commit && !srst && !we_q && acc_valid && ({1'b0, d_lane} < acc_n);
            f_lane  = 2'(gi) - f_addr[1:0];
            f_byte  = {1'b0, f_addr} + (ADDR_W + 1)'(f_lane);
            f_row   = RIDX_W'(f_byte >> 2);
            f_en    = f_req && f_ok && !f_lane[1];
        end

        // Write-first on the fetch side: a byte committed at this edge is forwarded to the fetch.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[d_row] <= wr_byte;
            end
            if (rd_en) begin
                d_rd_q <= mem[d_row];
            end
            if (f_en) begin
                f_rd_q <= (wr_en && (d_row == f_row)) ? wr_byte : mem[f_row];
            end
        end

        assign d_bank_rdata[gi] = d_rd_q;
        assign f_bank_rdata[gi] = f_rd_q;
    end

    always_comb begin
        d_rdata = 32'd0;
        if (rd_ok_q) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < rd_n_q) begin
                    d_rdata[8*k +: 8] = d_bank_rdata[2'(rd_rot_q + 2'(k))];
                end
            end
        end
    end

    always_comb begin
        f_hi_sel = f_base_q + 2'd1;
        f_data   = 16'h0000;
        if (f_has_q) begin
            f_data = f_flt_q ? FAULT_FETCH : {f_bank_rdata[f_hi_sel], f_bank_rdata[f_base_q]};
        end
    end

    assign d_ready  = (state_q != ACCESS) && !srst;
    assign d_rvalid = rvalid_q;
    assign d_fault  = fault_q;
    assign f_valid  = fv_q;

endmodule

// File: tb/tb_external_memory_waited.sv
// Directed bench for external_memory_waited: three instances with 0, 2 and 3 wait states
// exercised by hand-computed vectors for lanes, boundaries, wait states, forwarding and reset.
module tb_external_memory_waited;

    logic        clk = 1'b0;
    logic        srst     [3];
    logic        d_req    [3];
    logic        d_we     [3];
    logic [1:0]  d_size   [3];
    logic [9:0]  d_addr   [3];
    logic [31:0] d_wdata  [3];
    logic        d_ready  [3];
    logic        d_rvalid [3];
    logic [31:0] d_rdata  [3];
    logic        d_fault  [3];
    logic        f_req    [3];
    logic [9:0]  f_addr   [3];
    logic        f_valid  [3];
    logic [15:0] f_data   [3];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        external_memory_waited #(
            .MEM_BYTES  (1024),
            .ADDR_W     (10),
            .WAIT_CYCLES((gi == 0) ? 0 : (gi == 1) ? 2 : 3),
            .FAULT_FETCH(16'hE800)
        ) u_dut (
            .clk     (clk),
            .srst    (srst[gi]),
            .d_req   (d_req[gi]),
            .d_we    (d_we[gi]),
            .d_size  (d_size[gi]),
            .d_addr  (d_addr[gi]),
            .d_wdata (d_wdata[gi]),
            .d_ready (d_ready[gi]),
            .d_rvalid(d_rvalid[gi]),
            .d_rdata (d_rdata[gi]),
            .d_fault (d_fault[gi]),
            .f_req   (f_req[gi]),
            .f_addr  (f_addr[gi]),
            .f_valid (f_valid[gi]),
            .f_data  (f_data[gi])
        );
    end

    function automatic int wait_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            $display("ok   %s: 0x%08h (cycle %0d)", tag, obs, cyc);
        end
    endtask

    // One data-port transaction; checks response latency and returns the response.
    task automatic access(input int i, input logic we, input logic [1:0] sz, input logic [9:0] a,
                          input logic [31:0] wd, input string tag,
                          output logic [31:0] rd, output logic flt);
        int t0;
        int lat;
        @(posedge clk);
        #1;
        d_req[i]   = 1'b1;
        d_we[i]    = we;
        d_size[i]  = sz;
        d_addr[i]  = a;
        d_wdata[i] = wd;
        t0 = cyc;
        @(posedge clk);
        #1;
        d_req[i] = 1'b0;
        lat = -1;
        rd  = 32'd0;
        flt = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (d_rvalid[i]) begin
                lat = cyc - t0;
                rd  = d_rdata[i];
                flt = d_fault[i];
                break;
            end
        end
        check({tag, "_lat"}, lat, wait_of(i) + 2);
    endtask

    // One fetch; checks the response cycle and that the following idle cycle holds the data.
    task automatic fetch(input int i, input logic [9:0] a, input logic [15:0] exp, input string tag);
        @(posedge clk);
        #1;
        f_req[i]  = 1'b1;
        f_addr[i] = a;
        @(posedge clk);
        #1;
        f_req[i]  = 1'b0;
        f_addr[i] = ~a;
        @(negedge clk);
        check({tag, "_valid"}, f_valid[i], 1);
        check(tag, f_data[i], exp);
        @(negedge clk);
        check({tag, "_idle"}, f_valid[i], 0);
        check({tag, "_hold"}, f_data[i], exp);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        flt;
        int          t0;
        int          seen;

        for (int i = 0; i < 3; i++) begin
            srst[i] = 1'b1; d_req[i] = 1'b0; d_we[i] = 1'b0; d_size[i] = 2'd0;
            d_addr[i] = 10'd0; d_wdata[i] = 32'd0; f_req[i] = 1'b0; f_addr[i] = 10'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) srst[i] = 1'b0;
        @(negedge clk);
        check("rst_ready", d_ready[0], 1);
        check("rst_rvalid", d_rvalid[0], 0);
        check("rst_rdata", d_rdata[0], 32'd0);
        check("rst_fault", d_fault[0], 0);
        check("rst_fvalid", f_valid[0], 0);
        check("rst_fdata", f_data[0], 16'h0000);

        // Basic write then reads of several sizes
        access(0, 1'b1, 2'd2, 10'd400, 32'hDEADBEEF, "wr400", rd, flt);
        check("wr400_fault", flt, 0);
        access(0, 1'b0, 2'd2, 10'd400, 32'd0, "rd400", rd, flt);
        check("rd400_data", rd, 32'hDEADBEEF);
        check("rd400_fault", flt, 0);
        access(0, 1'b0, 2'd0, 10'd401, 32'd0, "rd401b", rd, flt);
        check("rd401b_data", rd, 32'h000000BE);
        access(0, 1'b0, 2'd1, 10'd402, 32'd0, "rd402h", rd, flt);
        check("rd402h_data", rd, 32'h0000DEAD);

        // Back-to-back: second request accepted in the RESP cycle
        @(posedge clk);
        #1;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_size[0] = 2'd2; d_addr[0] = 10'd400;
        t0 = cyc;
        @(posedge clk);
        #1;
        d_req[0] = 1'b0;
        @(posedge clk);
        #1;
        d_req[0] = 1'b1; d_size[0] = 2'd0; d_addr[0] = 10'd401;
        @(negedge clk);
        check("b2b_first_rvalid", d_rvalid[0], 1);
        check("b2b_first_ready", d_ready[0], 1);
        check("b2b_first_data", d_rdata[0], 32'hDEADBEEF);
        @(posedge clk);
        #1;
        d_req[0] = 1'b0;
        @(negedge clk);
        check("b2b_gap_rvalid", d_rvalid[0], 0);
        @(negedge clk);
        check("b2b_second_rvalid", d_rvalid[0], 1);
        check("b2b_second_cycle", cyc - t0, 4);
        check("b2b_second_data", d_rdata[0], 32'h000000BE);

        // A write leaves the previous read data on d_rdata
        access(0, 1'b1, 2'd0, 10'd404, 32'hFFFFFF11, "wr404b", rd, flt);
        check("wr404b_rdata_held", rd, 32'h000000BE);

        fetch(0, 10'd400, 16'hBEEF, "f400");
        fetch(0, 10'd401, 16'hADBE, "f401");
        fetch(0, 10'd403, 16'h11DE, "f403_row_straddle");

        // Lane masking and the reserved size
        access(0, 1'b1, 2'd2, 10'd100, 32'h01020304, "wr100", rd, flt);
        access(0, 1'b1, 2'd0, 10'd101, 32'hFFFFFF99, "wr101b", rd, flt);
        access(0, 1'b0, 2'd2, 10'd100, 32'd0, "rd100", rd, flt);
        check("rd100_data", rd, 32'h01029904);
        access(0, 1'b1, 2'd3, 10'd100, 32'hFFFFFFFF, "wr100_rsv", rd, flt);
        check("wr100_rsv_fault", flt, 1);
        access(0, 1'b0, 2'd2, 10'd100, 32'd0, "rd100_after_rsv", rd, flt);
        check("rd100_after_rsv_data", rd, 32'h01029904);

        // Unaligned word
        access(0, 1'b1, 2'd2, 10'd201, 32'hCAFEF00D, "wr201", rd, flt);
        access(0, 1'b0, 2'd1, 10'd203, 32'd0, "rd203h", rd, flt);
        check("rd203h_data", rd, 32'h0000CAFE);
        access(0, 1'b0, 2'd2, 10'd201, 32'd0, "rd201", rd, flt);
        check("rd201_data", rd, 32'hCAFEF00D);

        // Top-of-memory boundary
        access(0, 1'b1, 2'd2, 10'd1020, 32'h11223344, "wr1020", rd, flt);
        check("wr1020_fault", flt, 0);
        access(0, 1'b1, 2'd2, 10'd1021, 32'hAABBCCDD, "wr1021", rd, flt);
        check("wr1021_fault", flt, 1);
        access(0, 1'b0, 2'd2, 10'd1020, 32'd0, "rd1020", rd, flt);
        check("rd1020_data", rd, 32'h11223344);
        access(0, 1'b0, 2'd0, 10'd1023, 32'd0, "rd1023b", rd, flt);
        check("rd1023b_fault", flt, 0);
        check("rd1023b_data", rd, 32'h00000011);
        access(0, 1'b0, 2'd1, 10'd1023, 32'd0, "rd1023h", rd, flt);
        check("rd1023h_fault", flt, 1);
        fetch(0, 10'd1023, 16'hE800, "f1023");
        fetch(0, 10'd1022, 16'h1122, "f1022");

        // Write-first forwarding: fetch issued in the cycle whose closing edge commits the write
        access(0, 1'b1, 2'd1, 10'd6, 32'h0000BBAA, "wr6_old", rd, flt);
        @(posedge clk);
        #1;
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_size[0] = 2'd1; d_addr[0] = 10'd6; d_wdata[0] = 32'h00001234;
        @(posedge clk);
        #1;
        d_req[0] = 1'b0;
        f_req[0] = 1'b1; f_addr[0] = 10'd6;
        @(posedge clk);
        #1;
        f_req[0] = 1'b0;
        @(negedge clk);
        check("fwd_rvalid", d_rvalid[0], 1);
        check("fwd_fvalid", f_valid[0], 1);
        check("fwd_fdata", f_data[0], 16'h1234);

        // Three wait states: ready low for four cycles, request during ACCESS ignored
        access(2, 1'b1, 2'd0, 10'd50, 32'h0000005A, "w3_wr50", rd, flt);
        @(posedge clk);
        #1;
        d_req[2] = 1'b1; d_we[2] = 1'b0; d_size[2] = 2'd0; d_addr[2] = 10'd50;
        t0 = cyc;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin
                d_req[2] = 1'b1; d_we[2] = 1'b1; d_addr[2] = 10'd50; d_wdata[2] = 32'h000000A5;
            end else begin
                d_req[2] = 1'b0;
            end
            @(negedge clk);
            check($sformatf("w3_ready_low_c%0d", k), d_ready[2], 0);
            check($sformatf("w3_rvalid_low_c%0d", k), d_rvalid[2], 0);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check("w3_rvalid_c5", d_rvalid[2], 1);
        check("w3_rvalid_cycle", cyc - t0, 5);
        check("w3_rdata", d_rdata[2], 32'h0000005A);
        @(negedge clk);
        check("w3_no_second_rvalid", d_rvalid[2], 0);
        access(2, 1'b0, 2'd0, 10'd50, 32'd0, "w3_rd50", rd, flt);
        check("w3_rd50_data", rd, 32'h0000005A);

        // Reset in the final ACCESS cycle drops the write
        access(1, 1'b1, 2'd0, 10'd20, 32'h00000055, "w2_wr20_old", rd, flt);
        @(posedge clk);
        #1;
        d_req[1] = 1'b1; d_we[1] = 1'b1; d_size[1] = 2'd0; d_addr[1] = 10'd20; d_wdata[1] = 32'h000000AA;
        @(posedge clk);
        #1;
        d_req[1] = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        srst[1] = 1'b1;
        @(posedge clk);
        #1;
        srst[1] = 1'b0;
        @(negedge clk);
        check("w2_ready_after_rst", d_ready[1], 1);
        check("w2_rdata_after_rst", d_rdata[1], 32'd0);
        seen = 0;
        if (d_rvalid[1]) seen++;
        repeat (6) begin
            @(negedge clk);
            if (d_rvalid[1]) seen++;
        end
        check("w2_no_rvalid_after_rst", seen, 0);
        access(1, 1'b0, 2'd0, 10'd20, 32'd0, "w2_rd20", rd, flt);
        check("w2_rd20_data", rd, 32'h00000055);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
